// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan driver: segment codes, digit states, commons.
// FND_LZ_BLANK_EN, when defined, blanks a zero in the leftmost digit.
package fnd_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] COM_OFF  = 4'b1111;

endpackage

// File: rtl/fnd_scan_bcd2seg.sv
// BCD to seven-segment decoder, {g,f,e,d,c,b,a} active-high.
// Non-decimal codes show a dash.
module bcd2seg
  import fnd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/fnd_scan.sv
// Four-digit multiplexed FND scan driver with blanking guard per slot.
// Define FND_LZ_BLANK_EN to blank a leading zero in the leftmost digit.
module fnd_scan
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       done_hi,
  input  logic [3:0] bcd_hh,
  input  logic [3:0] bcd_hl,
  input  logic       done_lo,
  input  logic [3:0] bcd_lh,
  input  logic [3:0] bcd_ll,
  input  logic       colon_on,
  output logic [7:0] seg,
  output logic [3:0] com
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

  logic [CW-1:0]   cnt_q, cnt_d;
  dig_e            state_q, state_d;
  logic [3:0][3:0] d_q, d_d;
  logic [3:0]      cur_q, cur_d;
  logic            dp_q, dp_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      com_q, com_d;
  logic [6:0]      seg7;

  bcd2seg u_dec (
    .bcd_i (cur_q),
    .seg_o (seg7)
  );

  always_comb begin
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    if (cnt_q == LAST)
      state_d = dig_e'(state_q + 2'd1);

    d_d = d_q;
    if (done_hi) begin
      d_d[3] = bcd_hh;
      d_d[2] = bcd_hl;
    end
    if (done_lo) begin
      d_d[1] = bcd_lh;
      d_d[0] = bcd_ll;
    end

    // Latch the slot's digit once so mid-slot loads wait for the next visit.
    cur_d = cur_q;
    dp_d  = dp_q;
    if (cnt_q == '0) begin
      cur_d = d_q[state_q];
      dp_d  = colon_on && (state_q == DIG2);
    end

    com_d = COM_OFF;
    seg_d = SEG_OFF;
    if (cnt_q >= BLK) begin
      com_d[state_q] = 1'b0;
      seg_d = ~{dp_q, seg7};
`ifdef FND_LZ_BLANK_EN
      if (state_q == DIG3 && cur_q == 4'd0)
        seg_d = SEG_OFF;
`else
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      state_q <= DIG0;
      d_q     <= '0;
      cur_q   <= '0;
      dp_q    <= 1'b0;
      seg_q   <= SEG_OFF;
      com_q   <= COM_OFF;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      d_q     <= d_d;
      cur_q   <= cur_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign seg = seg_q;
  assign com = com_q;

endmodule

// File: tb/tb_fnd_scan.sv
// Bench for fnd_scan: slot-timeline model checked every cycle plus literal checks.
// Honors FND_LZ_BLANK_EN when defined for the whole build.
module tb_fnd_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_hi = 1'b0;
  logic       done_lo = 1'b0;
  logic       colon_on = 1'b0;
  logic [3:0] bcd_hh = '0;
  logic [3:0] bcd_hl = '0;
  logic [3:0] bcd_lh = '0;
  logic [3:0] bcd_ll = '0;
  logic [7:0] seg;
  logic [3:0] com;

  fnd_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .rst      (rst),
    .clk      (clk),
    .done_hi  (done_hi),
    .bcd_hh   (bcd_hh),
    .bcd_hl   (bcd_hl),
    .done_lo  (done_lo),
    .bcd_lh   (bcd_lh),
    .bcd_ll   (bcd_ll),
    .colon_on (colon_on),
    .seg      (seg),
    .com      (com)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  bit go = 1'b0;

  logic [6:0] segtab [16];
  initial segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                     7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model: k counts cycles since reset release; output in cycle k+1 is
  // derived from where cycle k sits on the 4-slot timeline.
  int         k = 0;
  int         slot, pos;
  logic [3:0] md [4];
  logic [3:0] mcur = '0;
  logic       mdp = 1'b0;
  logic [7:0] eseg = 8'hFF;
  logic [3:0] ecom = 4'hF;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0;
      for (int i = 0; i < 4; i++) md[i] = '0;
      mcur = '0;
      mdp  = 1'b0;
      eseg = 8'hFF;
      ecom = 4'hF;
    end else begin
      slot = (k / SD) % 4;
      pos  = k % SD;
      if (pos == 0) begin
        mcur = md[slot];
        mdp  = colon_on && (slot == 2);
      end
      if (pos < BC) begin
        eseg = 8'hFF;
        ecom = 4'hF;
      end else begin
        ecom = ~(4'b0001 << slot);
        eseg = ~{mdp, segtab[mcur]};
`ifdef FND_LZ_BLANK_EN
        if (slot == 3 && mcur == 4'd0) eseg = 8'hFF;
`endif
      end
      if (done_hi) begin
        md[3] = bcd_hh;
        md[2] = bcd_hl;
      end
      if (done_lo) begin
        md[1] = bcd_lh;
        md[0] = bcd_ll;
      end
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      ncmp++;
      if (seg !== eseg || com !== ecom) begin
        nerr++;
        $display("FAIL scan k=%0d seg=%h com=%b required seg=%h com=%b",
                 k, seg, com, eseg, ecom);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Park on the negedge where the outputs reflect timeline cycle j.
  task automatic wait_f(input int j);
    int b = 0;
    while (k != j + 1 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (k != j + 1) begin
      ncmp++;
      nerr++;
      $display("FAIL wait_f%0d k=%0d required=%0d", j, k, j + 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    go = 1'b1;
    chk("rst_seg", seg, 8'hFF);
    chk("rst_com", {4'h0, com}, 8'h0F);
    rst = 1'b1;

    wait_f(0);  chk("f0_com", {4'h0, com}, 8'h0F);
    wait_f(2);  chk("f2_com", {4'h0, com}, 8'h0E); chk("f2_seg", seg, 8'hC0);
    wait_f(10); chk("f10_com", {4'h0, com}, 8'h0D);
    wait_f(18); chk("f18_com", {4'h0, com}, 8'h0B);
    wait_f(26); chk("f26_com", {4'h0, com}, 8'h07);
`ifdef FND_LZ_BLANK_EN
    chk("f26_seg", seg, 8'hFF);
`else
    chk("f26_seg", seg, 8'hC0);
`endif

    wait_f(32);
    done_lo = 1'b1; bcd_lh = 4'd4; bcd_ll = 4'd2;
    wait_f(35);
    done_lo = 1'b0;
    wait_f(38); chk("lo_old_dig0", seg, 8'hC0);
    wait_f(42); chk("lo_dig1", seg, 8'h99);
    wait_f(50); chk("lo_dig2", seg, 8'hC0);

    wait_f(64);
    done_hi = 1'b1; done_lo = 1'b1;
    bcd_hh = 4'd5; bcd_hl = 4'd9; bcd_lh = 4'd3; bcd_ll = 4'd7;
    wait_f(65);
    done_hi = 1'b0; done_lo = 1'b0;
    wait_f(66); chk("lo_dig0", seg, 8'hA4);
    wait_f(74); chk("both_dig1", seg, 8'hB0);
    wait_f(82); chk("both_dig2", seg, 8'h90);
    wait_f(90); chk("both_dig3", seg, 8'h92);
    wait_f(98); chk("both_dig0", seg, 8'hF8);

    wait_f(99);
    done_lo = 1'b1; bcd_ll = 4'd8;
    wait_f(100);
    done_lo = 1'b0;
    wait_f(102); chk("mid_hold", seg, 8'hF8);

    wait_f(129);
    colon_on = 1'b1; done_hi = 1'b1; bcd_hh = 4'd12; bcd_hl = 4'd9;
    wait_f(130);
    done_hi = 1'b0;
    chk("mid_next", seg, 8'h80);
    wait_f(138); chk("colon_dig1", seg, 8'hB0);
    wait_f(144); chk("colon_blank", seg, 8'hFF);
    wait_f(146); chk("colon_dig2", seg, 8'h10);
    wait_f(154); chk("dash_dig3", seg, 8'hBF);

    wait_f(159);
    done_hi = 1'b1; bcd_hh = 4'd0;
    wait_f(160);
    done_hi = 1'b0;
    wait_f(186);
    chk("lz_com", {4'h0, com}, 8'h07);
`ifdef FND_LZ_BLANK_EN
    chk("lz_seg", seg, 8'hFF);
`else
    chk("lz_seg", seg, 8'hC0);
`endif

    wait_f(211);
    chk("pre_rst_com", {4'h0, com}, 8'h0B);
    #1 rst = 1'b0;
    #1;
    chk("async_seg", seg, 8'hFF);
    chk("async_com", {4'h0, com}, 8'h0F);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_f(0);  chk("rel_com0", {4'h0, com}, 8'h0F);
    wait_f(1);  chk("rel_com1", {4'h0, com}, 8'h0F);
    wait_f(2);  chk("rel_com2", {4'h0, com}, 8'h0E); chk("rel_seg", seg, 8'hC0);
    wait_f(18); chk("rel_colon", seg, 8'h40);
    wait_f(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fnd_scan.md
# fnd_scan

Four-digit multiplexed seven-segment (FND) scan driver, the stage directly downstream of the stopwatch's two binary-to-BCD converters. It captures each converter's BCD digit pair while that converter's `done` is high, and time-multiplexes the four digits onto one shared segment bus with per-digit common enables. It inserts a blanking guard at every digit switch to suppress ghosting.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all commons off; must be < `SCAN_DIV`.
- `rst`  in  1  asynchronous, active-low reset.
- `clk`  in  1  system clock; the single clock for the block.
- `done_hi`  in  1  load strobe for the upper pair (minutes); high for several cycles.
- `bcd_hh`  in  4  upper-pair tens digit.
- `bcd_hl`  in  4  upper-pair ones digit.
- `done_lo`  in  1  load strobe for the lower pair (seconds).
- `bcd_lh`  in  4  lower-pair tens digit.
- `bcd_ll`  in  4  lower-pair ones digit.
- `colon_on`  in  1  lights the dp of digit 2 as the min/sec separator.
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- `com`  out  4  digit commons, active-low; `com[0]` is the rightmost digit.

## Operation
- Shadow registers `d3..d0` hold `bcd_hh,bcd_hl,bcd_lh,bcd_ll`.
  - `d3,d2` load on every clock where `done_hi`=1.
  - `d1,d0` load on every clock where `done_lo`=1.
  - The two pairs load independently; simultaneous strobes load all four.
- Slot counter `cnt` runs 0..`SCAN_DIV`-1 and wraps to 0.
- Scan FSM: `DIG0→DIG1→DIG2→DIG3→DIG0`. It advances when `cnt`=`SCAN_DIV`-1.
- At `cnt`=0 the current slot's shadow digit is copied into `cur`, with dp = `colon_on` when in `DIG2`, else 0.
  - A shadow load mid-slot does not change the digit being displayed.
  - It appears at that digit's next slot.
- Decode, BCD to segments (a..g, active-high before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10–15 display '-', which is g only.
- `com`:
  - While `cnt` < `BLANK_CYC`: `4'b1111`.
  - Otherwise: only the bit for the current state is low.
- `seg`:
  - While `cnt` < `BLANK_CYC`: `8'hFF`.
  - Otherwise: the inverted decode of `cur`.
- Reset values:
  - `seg`=`8'hFF`, `com`=`4'b1111`.
  - State `DIG0`, `cnt`=0, `d3..d0`=0, `cur`=0.
- Reset asserted mid-scan returns immediately to the reset values. After release, scanning restarts at `DIG0` with a full blank guard.

## Timing
- `seg` and `com` are registered and reflect the `cnt`/state/`cur` of the previous cycle (1-cycle latency).
- Strobe to visible: a load in cycle N is held in the shadow register at N+1. It is displayed in the first `DIG` slot for that digit whose `cnt`=0 falls at or after N+1.
- Full refresh period: 4·`SCAN_DIV` cycles. Lit time per digit per period: `SCAN_DIV`−`BLANK_CYC` cycles.
- `com` never has more than one bit low, including across the state wrap and reset release.
- No handshake back to the converters. A strobe held for k cycles reloads k times with identical data, which is harmless.

## Configuration
- `FND_LZ_BLANK_EN` defined: in `DIG3`, if `cur`=0 then `seg` forces `8'hFF` for the whole slot. `com[3]` still follows the normal pattern.
- Not defined: `DIG3` shows '0' normally.
- Other digits are never blanked by either setting.

## Structure
- Package `fnd_pkg` holds:
  - the segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`;
  - the state encoding `DIG0`..`DIG3` (2-bit);
  - the `COM_OFF` constant.
- Sub-module `bcd2seg` is the combinational 4-bit → 7-bit decoder. It is instantiated once, on `cur`.
- The counter, FSM, shadow registers and output registers stay in `fnd_scan`.

## Test plan
All scenarios use `SCAN_DIV`=8, `BLANK_CYC`=2.
- Reset, then release with no strobes → `com` cycles 1110/1101/1011/0111. Each pattern lasts 6 cycles, preceded by 2 cycles of 1111. `seg`=`8'hC0` ('0') whenever a `com` bit is low.
- `done_lo` 3 cycles with `bcd_lh`=4, `bcd_ll`=2 → `DIG0` shows `8'hA4`, `DIG1` shows `8'h99` from their next slots on. `DIG2`/`DIG3` stay '0'.
- `done_hi`=`done_lo`=1 in the same cycle with digits 5,9,3,7 → the next refresh shows 7,3,9,5 on `com[0..3]`.
- `done_lo` pulse at `cnt`=4 of `DIG0` with `bcd_ll`=8 → the rest of the slot still shows the old digit. The next `DIG0` slot shows `8'h80`.
- `colon_on`=1 → `seg[7]`=0 only during the lit part of `DIG2`. `bcd_hh`=12 loaded → `DIG3` shows `8'hBF`.
- `rst` low during `DIG2` lit time → same cycle `com`=1111, `seg`=FF. With `FND_LZ_BLANK_EN` defined and `bcd_hh`=0, `DIG3` `seg` stays FF.
